// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encodings and the default operand width.
package serial_add_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full-adder cell, the one shared arithmetic element that the
// serial controller steps across the operands one bit per clock.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational sum and carry of three input bits.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. Operands are captured on an accepted
// start, then fed LSB first through one full-adder cell, one bit per clock.
// Subtraction is A + ~B + 1. Results are registered on entry to DONE so that
// sum, carry and overflow appear together with the one-cycle done pulse.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out
);

    // Counter only needs to reach WIDTH-1; it is cleared on every start.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] a_sr_q,     a_sr_d;
    logic [WIDTH-1:0] b_sr_q,     b_sr_d;
    logic [WIDTH-1:0] sum_sr_q,   sum_sr_d;
    logic             carry_q,    carry_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [WIDTH-1:0] sum_out_q,  sum_out_d;
    logic             cout_out_q, cout_out_d;
    logic             ovf_out_q,  ovf_out_d;

    logic fa_sum;
    logic fa_cout;
    logic c_msb_in;

    fulladder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // On the final step the carry register holds the carry into the MSB.
    assign c_msb_in = carry_q;

    // Next-state logic: capture on start, shift one bit per clock, publish on the last bit.
    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        sum_sr_d   = sum_sr_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sum_out_d  = sum_out_q;
        cout_out_d = cout_out_q;
        ovf_out_d  = ovf_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d   = a_in;
                    b_sr_d   = sub ? ~b_in : b_in;
                    carry_d  = sub ? 1'b1 : cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_out_d  = {fa_sum, sum_sr_q[WIDTH-1:1]};
                    cout_out_d = fa_cout;
                    ovf_out_d  = c_msb_in ^ fa_cout;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            sum_sr_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_out_q  <= '0;
            cout_out_q <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            sum_sr_q   <= sum_sr_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_out_q  <= sum_out_d;
            cout_out_q <= cout_out_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum_out  = sum_out_q;
    assign cout_out = cout_out_q;
    assign ovf_out  = ovf_out_q;

endmodule
